// File: rtl/bram_stream_reader_pkg.sv
// bram_stream_reader_pkg: shared FSM state type and output buffer depth for the BRAM stream reader.
package bram_stream_reader_pkg;
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    localparam int BUF_DEPTH = 2;
endpackage

// File: rtl/bram_stream_reader_skid_fifo2.sv
// skid_fifo2: 2-entry FIFO with flush; head entry drives dout/valid directly.
module skid_fifo2
    import bram_stream_reader_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic [1:0]   occ
);
    logic [W-1:0] tail;
    logic do_pop, wr_head, wr_tail, shift;

    always_comb begin
        do_pop  = pop && occ != 2'd0;
        wr_head = push && (occ == 2'd0 || (do_pop && occ == 2'd1));
        wr_tail = push && (occ == 2'(BUF_DEPTH) || (occ == 2'd1 && !do_pop));
        shift   = do_pop && occ == 2'(BUF_DEPTH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ  <= 2'd0;
            dout <= '0;
            tail <= '0;
        end else begin
            occ  <= flush ? 2'd0 : occ + 2'(push) - 2'(do_pop);
            dout <= wr_head ? din : shift ? tail : dout;
            tail <= wr_tail ? din : tail;
        end
    end

    assign valid = occ != 2'd0;
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: streams `length` BRAM words from base_addr over valid/ready, hiding read latency.
// Optional BRAM_STREAM_READER_COUNT_EN adds a words_read handshake counter output.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS:0]   length,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS-1:0] rd_addr,
    input  logic [DATA_BITS-1:0] rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data
`ifdef BRAM_STREAM_READER_COUNT_EN
    ,
    output logic [ADDR_BITS:0]   words_read
`endif
);
    state_t state, state_nxt;
    logic [ADDR_BITS:0] remaining;
    logic [1:0] occ;
    logic in_flight, done_q;
    logic accept, launch, zero_start, pop, issue, last_issue, drain_done;

    // A read is allowed when buffered + in-flight words leave room, counting a same-cycle pop.
    always_comb begin
        accept     = state == IDLE && start && !abort;
        launch     = accept && length != '0;
        zero_start = accept && length == '0;
        pop        = out_valid && out_ready;
        issue      = state == READ && !abort &&
                     (3'(occ) + 3'(in_flight)) < (3'(BUF_DEPTH) + 3'(pop));
        last_issue = issue && remaining == (ADDR_BITS+1)'(1);
        drain_done = state == DRAIN && occ == 2'd0 && !in_flight && !abort;
        state_nxt  = abort ? IDLE : launch ? READ : last_issue ? DRAIN : drain_done ? IDLE : state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr   <= '0;
            remaining <= '0;
            in_flight <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rd_addr   <= launch ? base_addr : issue ? rd_addr + 1'b1 : rd_addr;
            remaining <= launch ? length : issue ? remaining - 1'b1 : remaining;
            in_flight <= issue;
            done_q    <= zero_start;
        end
    end

`ifdef BRAM_STREAM_READER_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    words_read <= '0;
        else if (accept) words_read <= '0;
        else if (pop)    words_read <= words_read + 1'b1;
    end
`endif

    skid_fifo2 #(.W(DATA_BITS)) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (in_flight),
        .pop     (pop),
        .flush   (abort),
        .din     (rd_data),
        .dout    (out_data),
        .valid   (out_valid),
        .occ     (occ)
    );

    assign busy = state != IDLE;
    assign done = done_q | drain_done;
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: directed + randomized bench with a BRAM model and a word-queue reference.
module tb_bram_stream_reader;
    logic        clk, reset_n, start, abort, out_ready;
    logic [7:0]  base_addr, rd_addr;
    logic [8:0]  length;
    logic        busy, done, out_valid;
    logic [63:0] rd_data, out_data;
`ifdef BRAM_STREAM_READER_COUNT_EN
    logic [8:0]  words_read;
`endif

    bram_stream_reader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef BRAM_STREAM_READER_COUNT_EN
        ,
        .words_read(words_read)
`endif
    );

    logic [63:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 64'hA000 + 64'(i);
    always @(posedge clk) rd_data <= mem[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc, hs, done_cnt, done_cyc, first_v, first_hs, last_hs;
    bit busy_seen, stall_prev;
    logic [63:0] stall_data;
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor one cycle mid-period, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (stall_prev) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", out_data, stall_data);
        end
        if (out_valid && first_v < 0) first_v = cyc;
        if (out_valid && out_ready) begin
            chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("word_data", out_data, exp_q.pop_front());
            if (hs == 0) first_hs = cyc;
            last_hs = cyc;
            hs++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_seen = 1'b1;
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_xfer(input int base, input int len);
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(64'hA000 + 64'((base + i) % 256));
        cyc = 0; hs = 0; done_cnt = 0; done_cyc = -1; first_v = -1; first_hs = -1; last_hs = -1;
        busy_seen = 1'b0; stall_prev = 1'b0;
        base_addr = 8'(base);
        length = 9'(len);
        start = 1'b1;
    endtask

    // mode: 0 ready always, 1 toggling, 2 random, 3 held low for 10 cycles
    task automatic run(input int base, input int len, input int mode);
        begin_xfer(base, len);
        while (done_cnt == 0 && cyc < 600) begin
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) :
                        mode == 2 ? 1'($urandom_range(0, 1)) : (cyc >= 10);
            if (mode == 3 && cyc == 10) begin
                chk("reads_ahead", 64'(8'(rd_addr - 8'(base))), 64'd2);
                chk("ahead_valid", 64'(out_valid), 64'd1);
                chk("ahead_no_hs", 64'(hs), 64'd0);
            end
            tick();
            start = 1'b0;
        end
        chk("done_seen", 64'(done_cnt), 64'd1);
        out_ready = 1'b1;
        repeat (2) tick();
        chk("done_once", 64'(done_cnt), 64'd1);
        chk("word_count", 64'(hs), 64'(len));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        base_addr = '0; length = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_addr", 64'(rd_addr), 64'd0);
`ifdef BRAM_STREAM_READER_COUNT_EN
        chk("rst_words_read", 64'(words_read), 64'd0);
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) tick();

        run(8'h10, 4, 0);
        chk("t1_latency", 64'(first_v), 64'd3);
        chk("t1_back_to_back", 64'(last_hs - first_hs), 64'd3);
        chk("t1_done_after_last", 64'(done_cyc - last_hs), 64'd1);

        run(8'hFE, 4, 0);
        run(8'h40, 8, 1);
        run(8'h60, 5, 3);

        run(8'h30, 0, 0);
        chk("len0_done_cycle", 64'(done_cyc), 64'd1);
        chk("len0_no_busy", 64'(busy_seen), 64'd0);
        chk("len0_no_valid", 64'(first_v < 0), 64'd1);

        begin_xfer(8'h20, 6);
        out_ready = 1'b1;
        while (hs < 2 && cyc < 50) begin
            tick();
            start = 1'b0;
        end
        chk("abort_hs_reached", 64'(hs), 64'd2);
        out_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        stall_prev = 1'b0;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        out_ready = 1'b1;
        repeat (4) tick();
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_no_more_words", 64'(hs), 64'd2);
`ifdef BRAM_STREAM_READER_COUNT_EN
        chk("abort_words_read", 64'(words_read), 64'd2);
`endif
        run(8'h00, 1, 0);
`ifdef BRAM_STREAM_READER_COUNT_EN
        chk("restart_words_read", 64'(words_read), 64'd1);
`endif

        run(8'h80, 256, 0);
        for (int n = 0; n < 6; n++) run(int'($urandom_range(0, 255)), int'($urandom_range(1, 12)), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
